sig_approx_mult_pipe: RTL



---
 rtl/sig_approx_mult_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sig_approx_mult_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sig_approx_mult_pipe
// Description : Parametrised, pipelined signed (two's-complement) approximate
//               multiplier with a valid/ready streaming interface.
//               In approximate mode each of the low APPROX_COLS partial-product
//               columns is replaced by the OR of its bits. In exact mode the
//               full product is returned.
//
// Parameters  : WIDTH       operand width (4..32)
//               APPROX_COLS number of approximated low columns (0..WIDTH-1)
//               STAGES      register stages from acceptance to output (1..4)
//
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   operand beat valid
//               in_ready   block can accept a beat
//               x, y       signed operands (WIDTH bits)
//               approx_en  1 = approximate, 0 = exact (travels with the beat)
//               out_valid  result valid
//               out_ready  downstream accepts the result
//               z          signed product (2*WIDTH bits)
//
// Optional    : define SIG_APPROX_MULT_ERR_STAT_EN to add
//               stat_clr   synchronous clear of err_cnt
//               err_cnt    saturating count of consumed beats whose
//                          approximate result differs from the exact product
//
// Revision    : 1.0 - initial release
// ============================================================================
module sig_approx_mult_pipe #(
    parameter int WIDTH       = 16,
    parameter int APPROX_COLS = 8,
    parameter int STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z
`ifdef SIG_APPROX_MULT_ERR_STAT_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          err_cnt
`endif
);

    localparam int c_PROD_W = 2 * WIDTH;

    // ------------------------------------------------------------------------
    // Exact product. Sign-extending both operands to 2*WIDTH and multiplying
    // modulo 2^(2*WIDTH) gives the same value as the Baugh-Wooley array with
    // its inverted sign terms and the two correction ones.
    // ------------------------------------------------------------------------
    logic [c_PROD_W-1:0] w_x_ext;
    logic [c_PROD_W-1:0] w_y_ext;
    logic [c_PROD_W-1:0] w_exact;

    assign w_x_ext = {{WIDTH{x[WIDTH-1]}}, x};
    assign w_y_ext = {{WIDTH{y[WIDTH-1]}}, y};
    assign w_exact = w_x_ext * w_y_ext;

    // ------------------------------------------------------------------------
    // Approximation error. Column c (c < APPROX_COLS <= WIDTH-1) holds only
    // plain x[i]&y[c-i] terms. Replacing the column by its OR loses
    // (popcount - OR) units of weight 2^c; the per-column losses are chained
    // into a running sum that is subtracted from the exact product.
    // ------------------------------------------------------------------------
    logic [c_PROD_W-1:0] w_corr_acc [APPROX_COLS+1];

    assign w_corr_acc[0] = '0;

    for (genvar c = 0; c < APPROX_COLS; c++) begin : g_col
        logic [c:0]          w_col_bits;
        logic [c_PROD_W-1:0] w_col_err;

        for (genvar i = 0; i <= c; i++) begin : g_bit
            assign w_col_bits[i] = x[i] & y[c-i];
        end

        assign w_col_err = (c_PROD_W'($countones(w_col_bits))
                            - c_PROD_W'(|w_col_bits)) << c;
        assign w_corr_acc[c+1] = w_corr_acc[c] + w_col_err;
    end

    logic [c_PROD_W-1:0] w_z_next;

    assign w_z_next = approx_en ? (w_exact - w_corr_acc[APPROX_COLS]) : w_exact;

    // ------------------------------------------------------------------------
    // Pipeline. One global advance signal: every stage (bubble or not) moves
    // only when the output is free or being consumed, so a stall freezes the
    // whole pipe and z/out_valid stay put.
    // ------------------------------------------------------------------------
    logic                             w_advance;
    logic [STAGES-1:0]                r_valid;
    logic [STAGES-1:0][c_PROD_W-1:0]  r_z;
    logic [STAGES:0]                  w_valid_shift;
    logic [STAGES:0][c_PROD_W-1:0]    w_z_shift;

    assign w_advance     = out_ready | ~r_valid[STAGES-1];
    assign w_valid_shift = {r_valid, in_valid};
    assign w_z_shift     = {r_z, w_z_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_z     <= '0;
        end else if (w_advance) begin
            r_valid <= w_valid_shift[STAGES-1:0];
            r_z     <= w_z_shift[STAGES-1:0];
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_valid[STAGES-1];
    assign z         = r_z[STAGES-1];

`ifdef SIG_APPROX_MULT_ERR_STAT_EN
    // ------------------------------------------------------------------------
    // Error statistics. A beat differs from the exact product exactly when it
    // is approximate and its column loss is non-zero; that flag rides along
    // with the beat so the count is taken at consumption time.
    // ------------------------------------------------------------------------
    logic                w_err_next;
    logic [STAGES-1:0]   r_err;
    logic [STAGES:0]     w_err_shift;
    logic [31:0]         r_err_cnt;

    assign w_err_next  = approx_en & (|w_corr_acc[APPROX_COLS]);
    assign w_err_shift = {r_err, w_err_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (w_advance) begin
            r_err <= w_err_shift[STAGES-1:0];
        end
    end

    // Clear takes priority over a same-cycle increment; the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (stat_clr) begin
            r_err_cnt <= '0;
        end else if (out_valid && out_ready && r_err[STAGES-1] && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire
